// File: rtl/inst_loader.sv
// Boot-image loader: receives a big-endian byte stream (word count, payload,
// checksum) and writes it into instruction RAM as 32-bit words while holding
// the CPU off.
//
// Byte handshake: a byte transfers on a rising edge where i_byte_valid and
// o_byte_ready are both 1. i_byte_data is ignored on any other edge, and the
// source may hold i_byte_valid low for any length of time.
module inst_loader #(
  parameter int          ADDR_W    = 17,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,      // asynchronous, active-low
  input  logic        i_start,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte_data,
  output logic        o_byte_ready,
  output logic        o_we,
  output logic [31:0] o_waddr,
  output logic [31:0] o_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_cpu_hold,
  output logic [2:0]  o_state       // current FSM state, for debug/checkers
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // Largest legal image, in words. One bit wider than a 32-bit count so that
  // the oversize compare cannot wrap.
  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

  state_t            r_state;
  logic              r_byte_ready;
  logic              r_we;
  logic [31:0]       r_waddr;
  logic [31:0]       r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [1:0]        r_bcnt;    // byte position within the current header/word
  logic [31:0]       r_shift;   // header or payload word being assembled
  logic [7:0]        r_sum;     // running payload checksum, wraps mod 256
  logic [ADDR_W:0]   r_nwords;  // word count from the header
  logic [ADDR_W:0]   r_idx;     // index of the next word to write

  logic              w_fire;
  logic [31:0]       w_next;
  logic [ADDR_W:0]   w_idx_next;
  logic [31:0]       w_waddr;

  assign w_fire     = i_byte_valid & r_byte_ready;
  assign w_next     = {r_shift[23:0], i_byte_data};
  assign w_idx_next = r_idx + 1'b1;
  assign w_waddr    = BASE_ADDR + (32'(r_idx) << 2);

  // Loader FSM with all outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_waddr      <= BASE_ADDR;
      r_wdata      <= 32'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_bcnt       <= 2'd0;
      r_shift      <= 32'd0;
      r_sum        <= 8'd0;
      r_nwords     <= '0;
      r_idx        <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state      <= S_LEN;
            r_byte_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_bcnt       <= 2'd0;
            r_shift      <= 32'd0;
            r_sum        <= 8'd0;
            r_idx        <= '0;
          end
        end
        S_LEN: begin
          if (w_fire) begin
            r_shift <= w_next;
            r_bcnt  <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              r_nwords <= w_next[ADDR_W:0];
              if ({1'b0, w_next} > MAX_WORDS) begin
                r_state      <= S_ERR;
                r_byte_ready <= 1'b0;
              end else if (w_next == 32'd0) begin
                r_state <= S_CSUM;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          // byte_ready stays high across the write cycle so bytes may stream
          // back-to-back.
          if (w_fire) begin
            r_shift <= w_next;
            r_bcnt  <= r_bcnt + 2'd1;
            r_sum   <= r_sum + i_byte_data;
            if (r_bcnt == 2'd3) begin
              r_we    <= 1'b1;
              r_wdata <= w_next;
              r_waddr <= w_waddr;
              r_idx   <= w_idx_next;
              if (w_idx_next == r_nwords) begin
                r_state <= S_CSUM;
              end
            end
          end
        end
        S_CSUM: begin
          if (w_fire) begin
            r_byte_ready <= 1'b0;
            r_state      <= (i_byte_data == r_sum) ? S_DONE : S_ERR;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_err   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state      <= S_IDLE;
          r_byte_ready <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign o_byte_ready = r_byte_ready;
  assign o_we         = r_we;
  assign o_waddr      = r_waddr;
  assign o_wdata      = r_wdata;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_cpu_hold   = r_busy;
  assign o_state      = r_state;

endmodule
